// File: rtl/classifier_seq_pkg.sv
// Shared sizing, state encoding and helpers for the classifier sequencer and its MAC/argmax peer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package classifier_seq_pkg;

    localparam int N_FEAT     = 16;   // features per vector
    localparam int N_CLASS    = 8;    // number of classes
    localparam int CLASS_BITS = 3;    // class index width
    localparam int ACC_BITS   = 20;   // accumulator / score width
    localparam int DRAIN_CYC  = 2;    // MAC pipeline depth after the last pair
    localparam int WA_BITS    = $clog2(N_CLASS * N_FEAT);

    // A single-feature build still needs a 1-bit counter.
    localparam int FEAT_BITS  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int DRAIN_BITS = $clog2(DRAIN_CYC + 1) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_last_feat(input logic [FEAT_BITS-1:0] f);
        return f == FEAT_BITS'(N_FEAT - 1);
    endfunction

    function automatic logic is_last_class(input logic [CLASS_BITS-1:0] c);
        return c == CLASS_BITS'(N_CLASS - 1);
    endfunction

endpackage

// File: rtl/classifier_seq_feat_buf.sv
// Feature vector store: N_FEAT x int4 register file, one sync write port, one async read port.
// Latency: write visible the cycle after i_wr_en; read is combinational.
// Backpressure: none; caller guarantees addresses are in range.
//
// Ports:
//   clk, rst_n  clock, async active-low clear of every entry
//   i_wr_en     write strobe; i_wr_addr / i_wr_data select entry and value
//   i_rd_addr   read index; o_rd_data returns the stored int4
module classifier_seq_feat_buf
    import classifier_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [FEAT_BITS-1:0]  i_wr_addr,
    input  logic signed [3:0]     i_wr_data,
    input  logic [FEAT_BITS-1:0]  i_rd_addr,
    output logic signed [3:0]     o_rd_data
);

    logic signed [3:0] r_mem [N_FEAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_FEAT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/classifier_seq.sv
// Sequencer ahead of the int4 x int8 MAC/argmax: buffers one feature vector, walks the weight ROM, latches the winner.
// Latency: pair presented 1 cycle after its ROM address; done DRAIN_CYC+1 cycles after the last pair.
// Backpressure: feat_ready only in LOAD, stalls indefinitely waiting for beats; RUN never stalls.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset (aborts any run, clears results)
//   start / busy                   launch from IDLE only / high outside IDLE
//   feat_valid/feat_ready/feat_data  int4 feature stream, N_FEAT beats per run
//   w_rd_en / w_addr / w_data      weight ROM port, data returns one cycle after the strobe
//   x_int4 / w_int8 / new_feat / new_class / class_id   aligned pair stream to the MAC
//   max_score_in / max_class_in    running argmax from the MAC stage
//   done / result_class / result_score  completion pulse and latched result
module classifier_seq
    import classifier_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    input  logic                   feat_valid,
    output logic                   feat_ready,
    input  logic signed [3:0]      feat_data,
    output logic                   w_rd_en,
    output logic [WA_BITS-1:0]     w_addr,
    input  logic signed [7:0]      w_data,
    output logic signed [3:0]      x_int4,
    output logic signed [7:0]      w_int8,
    output logic                   new_feat,
    output logic                   new_class,
    output logic [CLASS_BITS-1:0]  class_id,
    input  logic [ACC_BITS-1:0]    max_score_in,
    input  logic [CLASS_BITS-1:0]  max_class_in,
    output logic                   done,
    output logic [CLASS_BITS-1:0]  result_class,
    output logic [ACC_BITS-1:0]    result_score
);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [FEAT_BITS-1:0]   r_feat_cnt;     // write index in LOAD, read index in RUN
    logic [CLASS_BITS-1:0]  r_class_cnt;
    logic [WA_BITS-1:0]     r_addr;
    logic [DRAIN_BITS-1:0]  r_drain_cnt;

    logic                   r_new_feat;
    logic                   r_new_class;
    logic signed [3:0]      r_x;
    logic [CLASS_BITS-1:0]  r_class_id;
    logic [CLASS_BITS-1:0]  r_result_class;
    logic [ACC_BITS-1:0]    r_result_score;

    logic                   w_load_beat;
    logic                   w_feat_last;
    logic                   w_run_last;
    logic                   w_drain_end;
    logic                   w_run;
    logic signed [3:0]      w_buf_rd;

    assign w_run       = (r_state == ST_RUN);
    assign w_load_beat = feat_valid && (r_state == ST_LOAD);
    assign w_feat_last = is_last_feat(r_feat_cnt);
    assign w_run_last  = w_feat_last && is_last_class(r_class_cnt);
    assign w_drain_end = (r_drain_cnt == DRAIN_BITS'(DRAIN_CYC));

    classifier_seq_feat_buf u_feat_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_load_beat),
        .i_wr_addr (r_feat_cnt),
        .i_wr_data (feat_data),
        .i_rd_addr (r_feat_cnt),
        .o_rd_data (w_buf_rd)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)                     w_state_nxt = ST_LOAD;
            ST_LOAD:  if (w_load_beat && w_feat_last) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_run_last)                w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_end)               w_state_nxt = ST_DONE;
            ST_DONE:                                 w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (r_state != ST_IDLE);
        feat_ready = (r_state == ST_LOAD);
        w_rd_en    = w_run;
        w_addr     = w_run ? r_addr : '0;
        done       = (r_state == ST_DONE);
    end

    // ---------------- Counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat_cnt  <= '0;
            r_class_cnt <= '0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_feat_cnt  <= '0;
                    r_class_cnt <= '0;
                    r_addr      <= '0;
                    r_drain_cnt <= '0;
                end
                ST_LOAD: begin
                    // Wraps to 0 on the last beat so RUN starts at feature 0.
                    if (w_load_beat) begin
                        r_feat_cnt <= w_feat_last ? '0 : r_feat_cnt + FEAT_BITS'(1);
                    end
                end
                ST_RUN: begin
                    r_addr <= r_addr + WA_BITS'(1);
                    if (w_feat_last) begin
                        r_feat_cnt  <= '0;
                        r_class_cnt <= r_class_cnt + CLASS_BITS'(1);
                    end else begin
                        r_feat_cnt  <= r_feat_cnt + FEAT_BITS'(1);
                    end
                end
                ST_DRAIN: r_drain_cnt <= r_drain_cnt + DRAIN_BITS'(1);
                default: ;
            endcase
        end
    end

    // ---------------- Pair pipeline ----------------
    // Registered one stage so x/flags line up with ROM data, which returns a cycle after the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_feat  <= 1'b0;
            r_new_class <= 1'b0;
            r_x         <= '0;
            r_class_id  <= '0;
        end else begin
            r_new_feat  <= w_run;
            r_new_class <= w_run && (r_feat_cnt == '0);
            r_x         <= w_run ? w_buf_rd : 4'sd0;
            if (w_run) begin
                r_class_id <= r_class_cnt;
            end
        end
    end

    assign x_int4    = r_x;
    assign new_feat  = r_new_feat;
    assign new_class = r_new_class;
    assign class_id  = r_class_id;
    assign w_int8    = r_new_feat ? w_data : 8'sd0;

    // ---------------- Result latch ----------------
    // Sampled on the edge into DONE (DRAIN_CYC cycles after the last pair) so result_* are
    // already updated while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_class <= '0;
            r_result_score <= '0;
        end else if ((r_state == ST_DRAIN) && w_drain_end) begin
            r_result_class <= max_class_in;
            r_result_score <= max_score_in;
        end
    end

    assign result_class = r_result_class;
    assign result_score = r_result_score;

endmodule
